// File: rtl/pll_bclksclk_pkg.sv
// Shared types and constants for the VCO phase-select rotator and its tap registers.
package pll_bclksclk_pkg;

   localparam int TAP_W   = 3;
   localparam int TAP_CNT = 8;
   localparam int ROT_W   = 7;
   localparam int CNT_W   = 5;

   localparam logic [ROT_W-1:0] ROT_MAX = 7'd127;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } rot_state_t;

   // One tap step around the ring, wrapping at both ends.
   function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap,
                                                 input logic             up);
      if (up)
         tap_step = (tap == TAP_W'(TAP_CNT - 1)) ? '0 : tap + 1'b1;
      else
         tap_step = (tap == '0) ? TAP_W'(TAP_CNT - 1) : tap - 1'b1;
   endfunction

endpackage

// File: rtl/pll_phs_tap.sv
// Modulo-8 up/down phase tap register; load restores the initial tap.
module pll_phs_tap
   import pll_bclksclk_pkg::*;
#(
   parameter logic [TAP_W-1:0] PHS_INIT = 3'd0
) (
   input  logic             sclk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             dir,
   output logic [TAP_W-1:0] tap
);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         tap <= PHS_INIT;
      else if (load)
         tap <= PHS_INIT;
      else if (step)
         tap <= tap_step(tap, dir);
   end

endmodule

// File: rtl/pll_vcophs_rotator.sv
// VCO phase-select rotator: steps selected clock taps, then holds busy for a settle window.
//
// state  | meaning
// IDLE   | waiting for load or rotate request
// LOAD   | restore latched-select taps to PHS_INIT, clear rot_total
// SETTLE | busy; settle counter running down to 1
// DONE   | one-cycle rot_done pulse
module pll_vcophs_rotator
   import pll_bclksclk_pkg::*;
#(
   parameter int               SETTLE_CYCLES = 4,
   parameter logic [TAP_W-1:0] PHS_INIT      = 3'd0
) (
   input  logic             sclk,
   input  logic             reset,
   input  logic             loadphs_b,
   input  logic             vcophsel_rotate,
   input  logic             vcophsel_dir,
   input  logic             vcophsel_bclk_sel,
   input  logic             vcophsel_bclk90_sel,
   input  logic             vcophsel_sclk_sel,
   input  logic             vcophsel_mclk_sel,
   input  logic             clr_err,
   output logic [TAP_W-1:0] phs_bclk,
   output logic [TAP_W-1:0] phs_bclk90,
   output logic [TAP_W-1:0] phs_sclk,
   output logic [TAP_W-1:0] phs_mclk,
   output logic             busy,
   output logic             rot_done,
   output logic [ROT_W-1:0] rot_total,
   output logic             err_overrun,
   output logic             err_nosel
);

   rot_state_t       state, state_nxt;
   logic [CNT_W-1:0] settle_cnt;
   logic [3:0]       sel, sel_q, tap_ld, tap_st;
   logic             load_req, any_sel, rot_accept, load_accept;
   logic             ovr_evt, nosel_evt;

   assign sel         = {vcophsel_mclk_sel, vcophsel_sclk_sel, vcophsel_bclk90_sel, vcophsel_bclk_sel};
   assign any_sel     = |sel;
   assign load_req    = ~loadphs_b;
   assign rot_accept  = (state == ST_IDLE) && !load_req && vcophsel_rotate && any_sel;
   assign load_accept = load_req && (state != ST_LOAD);
   assign ovr_evt     = vcophsel_rotate && !load_req && ((state == ST_SETTLE) || (state == ST_DONE));
   assign nosel_evt   = vcophsel_rotate && !load_req && (state == ST_IDLE) && !any_sel;

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (load_req)
               state_nxt = ST_LOAD;
            else if (vcophsel_rotate && any_sel)
               state_nxt = ST_SETTLE;
         end
         ST_LOAD:
            state_nxt = ST_IDLE;
         ST_SETTLE: begin
            if (load_req)
               state_nxt = ST_LOAD;
            else if (settle_cnt <= CNT_W'(1))
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (load_req)
               state_nxt = ST_LOAD;
            else
               state_nxt = ST_IDLE;
         end
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ST_SETTLE);
      rot_done = (state == ST_DONE);
      tap_ld   = (state == ST_LOAD) ? sel_q : 4'b0000;
      tap_st   = rot_accept ? sel : 4'b0000;
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         settle_cnt <= '0;
      else if (rot_accept)
         settle_cnt <= CNT_W'(SETTLE_CYCLES);
      else if (state == ST_SETTLE)
         settle_cnt <= (load_req || settle_cnt == '0) ? '0 : settle_cnt - 1'b1;
   end

   // Load selects are captured at acceptance and applied during the LOAD cycle.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         sel_q <= 4'b0000;
      else if (load_accept)
         sel_q <= sel;
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         rot_total <= '0;
      else if (state == ST_LOAD)
         rot_total <= '0;
      else if (rot_accept && rot_total != ROT_MAX)
         rot_total <= rot_total + 1'b1;
   end

   // A same-cycle error event wins over clr_err.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         err_overrun <= 1'b0;
         err_nosel   <= 1'b0;
      end else begin
         if (ovr_evt)
            err_overrun <= 1'b1;
         else if (clr_err)
            err_overrun <= 1'b0;
         if (nosel_evt)
            err_nosel <= 1'b1;
         else if (clr_err)
            err_nosel <= 1'b0;
      end
   end

   pll_phs_tap #(.PHS_INIT(PHS_INIT)) u_tap_bclk (
      .sclk(sclk), .reset(reset), .load(tap_ld[0]), .step(tap_st[0]),
      .dir(vcophsel_dir), .tap(phs_bclk)
   );

   pll_phs_tap #(.PHS_INIT(PHS_INIT)) u_tap_bclk90 (
      .sclk(sclk), .reset(reset), .load(tap_ld[1]), .step(tap_st[1]),
      .dir(vcophsel_dir), .tap(phs_bclk90)
   );

   pll_phs_tap #(.PHS_INIT(PHS_INIT)) u_tap_sclk (
      .sclk(sclk), .reset(reset), .load(tap_ld[2]), .step(tap_st[2]),
      .dir(vcophsel_dir), .tap(phs_sclk)
   );

   pll_phs_tap #(.PHS_INIT(PHS_INIT)) u_tap_mclk (
      .sclk(sclk), .reset(reset), .load(tap_ld[3]), .step(tap_st[3]),
      .dir(vcophsel_dir), .tap(phs_mclk)
   );

endmodule

// File: tb/tb_pll_vcophs_rotator.sv
// Scoreboard bench for pll_vcophs_rotator: rot_done pulses are matched against queued expectations.
module tb_pll_vcophs_rotator;

   localparam int S = 4;

   logic       sclk = 1'b0;
   logic       reset = 1'b1;
   logic       loadphs_b = 1'b1;
   logic       vcophsel_rotate = 1'b0;
   logic       vcophsel_dir = 1'b0;
   logic       bs = 1'b0, b90 = 1'b0, ss = 1'b0, ms = 1'b0;
   logic       clr_err = 1'b0;
   logic [2:0] phs_bclk, phs_bclk90, phs_sclk, phs_mclk;
   logic       busy, rot_done, err_overrun, err_nosel;
   logic [6:0] rot_total;

   pll_vcophs_rotator #(.SETTLE_CYCLES(S), .PHS_INIT(3'd0)) dut (
      .sclk(sclk), .reset(reset), .loadphs_b(loadphs_b),
      .vcophsel_rotate(vcophsel_rotate), .vcophsel_dir(vcophsel_dir),
      .vcophsel_bclk_sel(bs), .vcophsel_bclk90_sel(b90),
      .vcophsel_sclk_sel(ss), .vcophsel_mclk_sel(ms),
      .clr_err(clr_err),
      .phs_bclk(phs_bclk), .phs_bclk90(phs_bclk90), .phs_sclk(phs_sclk), .phs_mclk(phs_mclk),
      .busy(busy), .rot_done(rot_done), .rot_total(rot_total),
      .err_overrun(err_overrun), .err_nosel(err_nosel)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      int          cyc;
      logic [11:0] phs;
      logic [6:0]  tot;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [2:0] m_phs[4];
   int         m_tot = 0;

   always @(posedge sclk) cyc++;

   function automatic logic [11:0] dut_phs();
      return {phs_mclk, phs_sclk, phs_bclk90, phs_bclk};
   endfunction

   function automatic logic [11:0] mdl_phs();
      return {m_phs[3], m_phs[2], m_phs[1], m_phs[0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge sclk) begin
      if (!reset && rot_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rot_done actual=pulse@%0d required=none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("done_cycle", cyc, mon_e.cyc);
            chk("done_phs", dut_phs(), mon_e.phs);
            chk("done_total", rot_total, mon_e.tot);
         end
      end
   end

   task automatic step_cyc(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic set_sel(input logic [3:0] sel);
      {ms, ss, b90, bs} = sel;
   endtask

   task automatic model_rot(input logic [3:0] sel, input logic d);
      for (int i = 0; i < 4; i++)
         if (sel[i]) m_phs[i] = 3'((int'(m_phs[i]) + (d ? 1 : 7)) % 8);
      if (m_tot < 127) m_tot++;
   endtask

   task automatic issue(input logic [3:0] sel, input logic d);
      set_sel(sel);
      vcophsel_dir    = d;
      vcophsel_rotate = 1'b1;
      step_cyc(1);
      vcophsel_rotate = 1'b0;
   endtask

   // Accepted rotate: scoreboards the rot_done, checks 1-cycle phase latency and busy width.
   task automatic rotate(input logic [3:0] sel, input logic d);
      exp_t e;
      int   nb;
      model_rot(sel, d);
      e.cyc = cyc + S + 1;
      e.phs = mdl_phs();
      e.tot = 7'(m_tot);
      sb.push_back(e);
      issue(sel, d);
      set_sel(~sel);
      vcophsel_dir = ~d;
      chk("rot_phs_latency", dut_phs(), mdl_phs());
      nb = 0;
      for (int k = 0; k <= S; k++) begin
         if (busy) nb++;
         step_cyc(1);
      end
      chk("busy_cycles", nb, S);
      chk("post_rot_phs", dut_phs(), mdl_phs());
      set_sel(4'b0000);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_phs"}, dut_phs(), 12'h000);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, rot_done, 0);
      chk({tag, "_total"}, rot_total, 0);
      chk({tag, "_errs"}, {err_overrun, err_nosel}, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_phs[i] = 3'd0;
      step_cyc(2);
      chk_reset_vals("reset");
      reset = 1'b0;
      step_cyc(1);

      // Nine +1 rotates on bclk/bclk90: wrap 7->0 and end at tap 1.
      for (int n = 0; n < 9; n++) rotate(4'b0011, 1'b1);
      chk("wrap_bclk", phs_bclk, 1);
      chk("wrap_bclk90", phs_bclk90, 1);
      chk("wrap_sclk", phs_sclk, 0);
      chk("wrap_mclk", phs_mclk, 0);
      chk("wrap_total", rot_total, 9);

      // -1 from tap 0 wraps to 7.
      rotate(4'b0100, 1'b0);
      chk("dec_wrap_sclk", phs_sclk, 7);

      // Overrun: second request 2 cycles into the settle window.
      begin
         exp_t e;
         model_rot(4'b1000, 1'b1);
         e.cyc = cyc + S + 1;
         e.phs = mdl_phs();
         e.tot = 7'(m_tot);
         sb.push_back(e);
         issue(4'b1000, 1'b1);
         step_cyc(1);
         issue(4'b1000, 1'b1);
         chk("overrun_flag", err_overrun, 1);
         step_cyc(S);
         chk("overrun_mclk", phs_mclk, 1);
         chk("overrun_total", rot_total, 11);
         clr_err = 1'b1;
         step_cyc(1);
         clr_err = 1'b0;
         chk("overrun_clr", err_overrun, 0);
      end

      // Rotate with no select.
      issue(4'b0000, 1'b1);
      chk("nosel_flag", err_nosel, 1);
      chk("nosel_busy", busy, 0);
      step_cyc(1);
      chk("nosel_busy2", busy, 0);
      chk("nosel_phs", dut_phs(), mdl_phs());
      chk("nosel_total", rot_total, 11);
      clr_err = 1'b1;
      step_cyc(1);
      clr_err = 1'b0;
      chk("nosel_clr", err_nosel, 0);

      // Load aborts a settle: no rot_done, selected taps restored, count cleared.
      issue(4'b0001, 1'b1);
      chk("abort_pre_phs", phs_bclk, 2);
      step_cyc(1);
      set_sel(4'b0011);
      loadphs_b = 1'b0;
      step_cyc(1);
      loadphs_b = 1'b1;
      set_sel(4'b0000);
      chk("abort_busy", busy, 0);
      step_cyc(1);
      m_phs[0] = 3'd0;
      m_phs[1] = 3'd0;
      m_tot = 0;
      chk("abort_phs", dut_phs(), {3'd1, 3'd7, 3'd0, 3'd0});
      chk("abort_total", rot_total, 0);
      step_cyc(S + 2);

      // Load wins over a same-cycle rotate with no error.
      set_sel(4'b1000);
      vcophsel_dir    = 1'b1;
      vcophsel_rotate = 1'b1;
      loadphs_b       = 1'b0;
      step_cyc(1);
      vcophsel_rotate = 1'b0;
      loadphs_b       = 1'b1;
      set_sel(4'b0000);
      step_cyc(1);
      m_phs[3] = 3'd0;
      chk("ldrot_mclk", phs_mclk, 0);
      chk("ldrot_errs", {err_overrun, err_nosel}, 0);
      chk("ldrot_busy", busy, 0);
      chk("ldrot_total", rot_total, 0);
      step_cyc(S + 2);

      // Saturation of rot_total.
      for (int n = 0; n < 200; n++) rotate(4'b0100, 1'b1);
      chk("sat_total", rot_total, 127);
      chk("sat_sclk", phs_sclk, 7);

      // Async reset mid-settle, with a sticky error pending.
      issue(4'b0000, 1'b1);
      issue(4'b0011, 1'b1);
      step_cyc(1);
      chk("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      step_cyc(2);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) m_phs[i] = 3'd0;
      m_tot = 0;
      step_cyc(S + 3);
      chk("post_rst_total", rot_total, 0);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_vcophs_rotator.md
PLL_VCOPHS_ROTATOR -- requirements
Module: pll_vcophs_rotator

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: busy cycles after each accepted rotate (legal 1..31).
REQ-002 SHALL have parameter PHS_INIT, default 3'd0: tap value restored on load.
REQ-003 SHALL have port sclk, in, 1: sole clock; one clock; all logic on the rising edge.
REQ-004 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have port loadphs_b, in, 1: active-low phase load request.
REQ-006 SHALL have port vcophsel_rotate, in, 1: one-cycle rotate request.
REQ-007 SHALL have port vcophsel_dir, in, 1: rotate direction; 1 = +1 tap, 0 = -1 tap.
REQ-008 SHALL have ports vcophsel_bclk_sel, vcophsel_bclk90_sel, vcophsel_sclk_sel and vcophsel_mclk_sel, in, 1 each: per-output select.
REQ-009 SHALL have port clr_err, in, 1: clears sticky error flags.
REQ-010 SHALL have ports phs_bclk, phs_bclk90, phs_sclk and phs_mclk, out, 3 each: current tap per output.
REQ-011 SHALL have port busy, out, 1: settle in progress.
REQ-012 SHALL have port rot_done, out, 1: one-cycle pulse when settle ends.
REQ-013 SHALL have port rot_total, out, 7: count of accepted rotates.
REQ-014 SHALL have ports err_overrun and err_nosel, out, 1 each: sticky error flags.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SETTLE and DONE.
REQ-016 IDLE -> LOAD SHALL occur when loadphs_b=0; load has priority over a same-cycle rotate, and that rotate SHALL be dropped silently.
REQ-017 In LOAD (1 cycle), each selected phs_* SHALL become PHS_INIT, rot_total SHALL become 0, and the FSM SHALL return to IDLE.
REQ-018 LOAD with no select asserted SHALL clear rot_total only.
REQ-019 IDLE with vcophsel_rotate=1 and at least one select SHALL cause each selected phs_* to step ±1 modulo 8 on the next edge (7+1 -> 0, 0-1 -> 7), with unselected outputs unchanged.
REQ-020 On an accepted rotate, the FSM SHALL enter SETTLE, load the settle counter with SETTLE_CYCLES, and increment rot_total saturating at 127.
REQ-021 In SETTLE, busy SHALL be 1 and the counter SHALL decrement each cycle; at 1 the FSM SHALL go to DONE.
REQ-022 busy SHALL be high for exactly SETTLE_CYCLES cycles per accepted rotate.
REQ-023 In DONE (1 cycle), rot_done SHALL be 1 and the FSM SHALL go to IDLE.
REQ-024 Rotate latency SHALL be: phase update 1 cycle after request; rot_done SETTLE_CYCLES+1 cycles after request.
REQ-025 A rotate in SETTLE or DONE SHALL be ignored (no phase or count change) and SHALL set err_overrun.
REQ-026 A rotate in IDLE with no select SHALL be ignored, SHALL set err_nosel, and SHALL leave the FSM in IDLE.
REQ-027 loadphs_b=0 in SETTLE or DONE SHALL abort the settle, return busy to 0 the next cycle, and enter LOAD with no rot_done.
REQ-028 clr_err=1 SHALL clear both error flags; if an error event occurs in the same cycle, set wins.
REQ-029 Select and dir inputs SHALL be sampled only in the cycle the rotate or load is accepted.

Reset
REQ-030 While reset=1, the FSM SHALL be in IDLE, all phs_* SHALL be PHS_INIT, rot_total SHALL be 0, the settle counter SHALL be 0, and busy, rot_done, err_overrun and err_nosel SHALL all be 0.
REQ-031 Reset asserted mid-SETTLE SHALL take effect immediately (asynchronously), and no rot_done SHALL follow.

Structure
REQ-032 FSM state encodings, the tap width (3), the tap count (8) and the rot_total maximum (127) SHALL live in shared package pll_bclksclk_pkg.
REQ-033 One sub-module, pll_phs_tap (a 3-bit modulo-8 up/down tap register with load), SHALL be instantiated four times.
REQ-034 The settle counter and FSM SHALL be in the top level.

Verification
REQ-035 Reset, then rotate with bclk_sel and bclk90_sel and dir=1, repeated 9 times with SETTLE_CYCLES=4 -> phs_bclk = phs_bclk90 = 1 after wrap, phs_sclk=0, rot_total=9, 9 rot_done pulses each 5 cycles after its request.
REQ-036 dir=0 rotate from tap 0 -> phs tap 7; busy high 4 cycles; rot_done pulse in the 5th cycle.
REQ-037 A second rotate 2 cycles after the first -> err_overrun=1, taps advanced by 1 only, rot_total +1; then clr_err -> err_overrun=0.
REQ-038 Rotate with all selects 0 -> err_nosel=1, busy stays 0, taps unchanged.
REQ-039 loadphs_b=0 during SETTLE -> busy drops, no rot_done, selected taps = PHS_INIT, rot_total=0; a same-cycle rotate with load -> dropped, no error.
REQ-040 200 accepted rotates -> rot_total saturates at 127; reset pulsed mid-SETTLE -> all outputs at reset values immediately.
